// File: rtl/mem_responder.sv
// Word memory answering rd/wr requests after latency_p wait states.
// One-cycle ready_o pulse per accepted request; err_o flags misaligned or rd+wr requests.
module mem_responder #(
   parameter int byte_addr_p = 10,
   parameter int latency_p   = 2
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic [byte_addr_p-1:0] addr_i,
   input  logic                   rd_en_i,
   input  logic                   wr_en_i,
   input  logic [31:0]            data_i,
   output logic [31:0]            data_o,
   output logic                   ready_o,
   output logic                   err_o,
   output logic [1:0]             state_o
);

   // Handshake: the requester raises rd_en_i/wr_en_i (the valid) and holds addr_i/data_i
   // stable; the request is taken at the first edge in IDLE and ready_o pulses for exactly
   // one cycle when it completes, after which the requester drops or replaces the request.

   localparam int word_w = byte_addr_p - 2;
   localparam int depth  = 1 << word_w;
   localparam int cnt_w  = (latency_p > 0) ? $clog2(latency_p + 1) : 1;
   localparam logic [cnt_w-1:0] cnt_init = cnt_w'(latency_p);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [cnt_w-1:0]  cnt_q, cnt_d;
   logic [word_w-1:0] addr_q;
   logic              rd_q;
   logic              err_q;

   logic              req_err;
   logic              accept;
   logic              enter_resp;
   logic [word_w-1:0] cur_addr;
   logic              cur_rd;
   logic              cur_err;

   logic [31:0]       mem [depth];

   always_comb begin
      req_err    = (addr_i[1:0] != 2'b00) || (rd_en_i && wr_en_i);
      accept     = (state_q == IDLE) && (rd_en_i || wr_en_i);
      enter_resp = (state_d == RESP) && (state_q != RESP);
      // With zero latency RESP is entered straight from IDLE, before the latches hold the request.
      if (state_q == IDLE) begin
         cur_addr = addr_i[byte_addr_p-1:2];
         cur_rd   = rd_en_i;
         cur_err  = req_err;
      end else begin
         cur_addr = addr_q;
         cur_rd   = rd_q;
         cur_err  = err_q;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (rd_en_i || wr_en_i) begin
               cnt_d   = cnt_init;
               state_d = (latency_p > 0) ? WAIT : RESP;
            end
         end
         WAIT: begin
            cnt_d = cnt_q - cnt_w'(1);
            if (cnt_q <= cnt_w'(1)) begin
               state_d = RESP;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         rd_q    <= 1'b0;
         err_q   <= 1'b0;
         data_o  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            addr_q <= addr_i[byte_addr_p-1:2];
            rd_q   <= rd_en_i;
            err_q  <= req_err;
         end
         if (enter_resp && cur_rd) begin
            data_o <= cur_err ? '0 : mem[cur_addr];
         end
      end
   end

   // Writes commit on the acceptance edge so a later read always sees them.
   always_ff @(posedge clk_i) begin
      if (!rst_i && accept && wr_en_i && !req_err) begin
         mem[addr_i[byte_addr_p-1:2]] <= data_i;
      end
   end

   assign ready_o = (state_q == RESP);
   assign err_o   = ready_o && err_q;
   assign state_o = state_q;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: three instances (latency 2, 0, 4) checked
// against a word-array reference model, directed scenarios plus randomized traffic.
module tb_mem_responder;

   logic        clk;
   logic        rst      [3];
   logic        rd_en    [3];
   logic        wr_en    [3];
   logic [9:0]  addr     [3];
   logic [31:0] data_in  [3];
   logic [31:0] data_out [3];
   logic        ready    [3];
   logic        err      [3];
   logic [1:0]  state    [3];

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   logic [31:0] model_mem  [3][256];
   logic [31:0] model_dout [3];
   logic        prev_ready [3];

   localparam logic [1:0] ST_IDLE = 2'd0;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      mem_responder #(
         .byte_addr_p(10),
         .latency_p  (g == 0 ? 2 : (g == 1 ? 0 : 4))
      ) u_dut (
         .clk_i  (clk),
         .rst_i  (rst[g]),
         .addr_i (addr[g]),
         .rd_en_i(rd_en[g]),
         .wr_en_i(wr_en[g]),
         .data_i (data_in[g]),
         .data_o (data_out[g]),
         .ready_o(ready[g]),
         .err_o  (err[g]),
         .state_o(state[g])
      );
   end

   // ---------------- clock / cycle counter / watchdog ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   // ready must never be high in two consecutive cycles
   initial begin
      for (int k = 0; k < 3; k++) prev_ready[k] = 1'b0;
      forever begin
         @(negedge clk);
         for (int k = 0; k < 3; k++) begin
            if (ready[k] === 1'b1) begin
               checks++;
               if (prev_ready[k] === 1'b1) begin
                  errors++;
                  $display("FAIL ready_single_pulse dut%0d: got high twice at cycle %0d, expected one-cycle pulse", k, cyc);
               end
            end
            prev_ready[k] = ready[k];
         end
      end
   end

   function automatic int lat_of(input int k);
      return (k == 0) ? 2 : ((k == 1) ? 0 : 4);
   endfunction

   // ---------------- reference model ----------------
   task automatic model_req(input int k, input logic rd, input logic wr, input logic [9:0] a,
                            input logic [31:0] d, output logic exp_err, output logic [31:0] exp_dout);
      exp_err = (a[1:0] != 2'b00) || (rd && wr);
      if (wr && !exp_err) model_mem[k][a[9:2]] = d;
      if (rd) model_dout[k] = exp_err ? 32'h0 : model_mem[k][a[9:2]];
      exp_dout = model_dout[k];
   endtask

   // ---------------- driver ----------------
   // Called at a falling edge; returns the cycle number at which ready was seen.
   task automatic send(input int k, input logic rd, input logic wr, input logic [9:0] a,
                       input logic [31:0] d, output int rcyc, output logic r_err,
                       output logic [31:0] r_dout);
      rd_en[k]   = rd;
      wr_en[k]   = wr;
      addr[k]    = a;
      data_in[k] = d;
      rcyc       = -1;
      r_err      = 1'bx;
      r_dout     = 'x;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (ready[k] === 1'b1) begin
            rcyc   = cyc;
            r_err  = err[k];
            r_dout = data_out[k];
            break;
         end
      end
      rd_en[k] = 1'b0;
      wr_en[k] = 1'b0;
      if (rcyc < 0) begin
         checks++;
         errors++;
         $display("FAIL ready_timeout dut%0d addr %0h: got no ready in 40 cycles, expected ready", k, a);
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      for (int k = 0; k < 3; k++) begin
         rst[k]        = 1'b1;
         rd_en[k]      = 1'b0;
         wr_en[k]      = 1'b0;
         addr[k]       = '0;
         data_in[k]    = '0;
         model_dout[k] = 32'h0;
      end
      repeat (2) @(posedge clk);
      #2;
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (ready[k] !== 1'b0) begin errors++; $display("FAIL reset_ready dut%0d: got %b expected 0", k, ready[k]); end
         checks++;
         if (err[k] !== 1'b0) begin errors++; $display("FAIL reset_err dut%0d: got %b expected 0", k, err[k]); end
         checks++;
         if (data_out[k] !== 32'h0) begin errors++; $display("FAIL reset_data dut%0d: got %h expected 0", k, data_out[k]); end
         checks++;
         if (state[k] !== ST_IDLE) begin errors++; $display("FAIL reset_state dut%0d: got %0d expected %0d", k, state[k], ST_IDLE); end
      end
      @(negedge clk);
      #2;
      for (int k = 0; k < 3; k++) rst[k] = 1'b0;
      repeat (2) @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (state[k] !== ST_IDLE || ready[k] !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle dut%0d: got state %0d ready %b expected idle, 0", k, state[k], ready[k]);
         end
      end
   endtask

   task automatic test_write_read();
      int c, r;
      logic e, ee;
      logic [31:0] dq, ed;
      @(negedge clk);
      c = cyc;
      model_req(0, 1'b0, 1'b1, 10'h010, 32'hDEADBEEF, ee, ed);
      send(0, 1'b0, 1'b1, 10'h010, 32'hDEADBEEF, r, e, dq);
      checks++;
      if (r - c - 1 !== lat_of(0)) begin errors++; $display("FAIL wr_latency: got %0d expected %0d", r - c - 1, lat_of(0)); end
      checks++;
      if (e !== ee) begin errors++; $display("FAIL wr_err: got %b expected %b", e, ee); end
      checks++;
      if (dq !== ed) begin errors++; $display("FAIL wr_data_hold: got %h expected %h", dq, ed); end
      @(negedge clk);
      c = cyc;
      model_req(0, 1'b1, 1'b0, 10'h010, 32'h0, ee, ed);
      send(0, 1'b1, 1'b0, 10'h010, 32'h0, r, e, dq);
      checks++;
      if (r - c - 1 !== lat_of(0)) begin errors++; $display("FAIL rd_latency: got %0d expected %0d", r - c - 1, lat_of(0)); end
      checks++;
      if (e !== ee) begin errors++; $display("FAIL rd_err: got %b expected %b", e, ee); end
      checks++;
      if (dq !== ed) begin errors++; $display("FAIL rd_data: got %h expected %h", dq, ed); end
   endtask

   task automatic test_back_to_back();
      int c, r1, r2;
      logic e1, e2, ee1, ee2;
      logic [31:0] dq1, dq2, ed1, ed2;
      // zero latency: preload first and last word, then two reads back to back
      @(negedge clk);
      model_req(1, 1'b0, 1'b1, 10'h000, 32'd1, ee1, ed1);
      send(1, 1'b0, 1'b1, 10'h000, 32'd1, r1, e1, dq1);
      model_req(1, 1'b0, 1'b1, 10'h3FC, 32'd2, ee2, ed2);
      send(1, 1'b0, 1'b1, 10'h3FC, 32'd2, r2, e2, dq2);
      checks++;
      if (e1 !== 1'b0 || e2 !== 1'b0) begin errors++; $display("FAIL preload_err: got %b%b expected 00", e1, e2); end
      @(negedge clk);
      c = cyc;
      model_req(1, 1'b1, 1'b0, 10'h000, 32'h0, ee1, ed1);
      send(1, 1'b1, 1'b0, 10'h000, 32'h0, r1, e1, dq1);
      model_req(1, 1'b1, 1'b0, 10'h3FC, 32'h0, ee2, ed2);
      send(1, 1'b1, 1'b0, 10'h3FC, 32'h0, r2, e2, dq2);
      checks++;
      if (r1 - c - 1 !== lat_of(1)) begin errors++; $display("FAIL lat0_latency: got %0d expected %0d", r1 - c - 1, lat_of(1)); end
      checks++;
      if (dq1 !== ed1) begin errors++; $display("FAIL lat0_first_word: got %h expected %h", dq1, ed1); end
      checks++;
      if (dq2 !== ed2) begin errors++; $display("FAIL lat0_last_word: got %h expected %h", dq2, ed2); end
      checks++;
      if (r2 - r1 !== lat_of(1) + 2) begin errors++; $display("FAIL lat0_throughput: got %0d expected %0d", r2 - r1, lat_of(1) + 2); end
      // latency 2: back-to-back reads are latency+2 apart
      @(negedge clk);
      model_req(0, 1'b1, 1'b0, 10'h010, 32'h0, ee1, ed1);
      send(0, 1'b1, 1'b0, 10'h010, 32'h0, r1, e1, dq1);
      model_req(0, 1'b1, 1'b0, 10'h010, 32'h0, ee2, ed2);
      send(0, 1'b1, 1'b0, 10'h010, 32'h0, r2, e2, dq2);
      checks++;
      if (r2 - r1 !== lat_of(0) + 2) begin errors++; $display("FAIL lat2_throughput: got %0d expected %0d", r2 - r1, lat_of(0) + 2); end
      checks++;
      if (dq2 !== ed2) begin errors++; $display("FAIL lat2_b2b_data: got %h expected %h", dq2, ed2); end
   endtask

   task automatic test_misaligned();
      int r;
      logic e, ee;
      logic [31:0] dq, ed;
      @(negedge clk);
      model_req(0, 1'b0, 1'b1, 10'h012, 32'd5, ee, ed);
      send(0, 1'b0, 1'b1, 10'h012, 32'd5, r, e, dq);
      checks++;
      if (e !== ee) begin errors++; $display("FAIL misaligned_err: got %b expected %b", e, ee); end
      checks++;
      if (dq !== ed) begin errors++; $display("FAIL misaligned_data_hold: got %h expected %h", dq, ed); end
      @(negedge clk);
      model_req(0, 1'b1, 1'b0, 10'h010, 32'h0, ee, ed);
      send(0, 1'b1, 1'b0, 10'h010, 32'h0, r, e, dq);
      checks++;
      if (e !== ee || dq !== ed) begin errors++; $display("FAIL misaligned_no_write: got %b/%h expected %b/%h", e, dq, ee, ed); end
   endtask

   task automatic test_conflict();
      int r;
      logic e, ee;
      logic [31:0] dq, ed;
      @(negedge clk);
      model_req(0, 1'b0, 1'b1, 10'h020, 32'h12345678, ee, ed);
      send(0, 1'b0, 1'b1, 10'h020, 32'h12345678, r, e, dq);
      @(negedge clk);
      model_req(0, 1'b1, 1'b1, 10'h020, 32'hFFFF0000, ee, ed);
      send(0, 1'b1, 1'b1, 10'h020, 32'hFFFF0000, r, e, dq);
      checks++;
      if (e !== ee) begin errors++; $display("FAIL conflict_err: got %b expected %b", e, ee); end
      checks++;
      if (dq !== ed) begin errors++; $display("FAIL conflict_data: got %h expected %h", dq, ed); end
      @(negedge clk);
      model_req(0, 1'b1, 1'b0, 10'h020, 32'h0, ee, ed);
      send(0, 1'b1, 1'b0, 10'h020, 32'h0, r, e, dq);
      checks++;
      if (e !== ee || dq !== ed) begin errors++; $display("FAIL conflict_no_write: got %b/%h expected %b/%h", e, dq, ee, ed); end
   endtask

   task automatic test_reset_mid();
      int r;
      bit seen;
      logic e, ee;
      logic [31:0] dq, ed;
      @(negedge clk);
      model_req(2, 1'b0, 1'b1, 10'h040, 32'hA5A5_0001, ee, ed);
      send(2, 1'b0, 1'b1, 10'h040, 32'hA5A5_0001, r, e, dq);
      // write accepted, then reset during WAIT: the write stays committed
      @(negedge clk);
      rd_en[2] = 1'b0; wr_en[2] = 1'b1; addr[2] = 10'h044; data_in[2] = 32'hB0B0_0002;
      @(posedge clk);
      model_mem[2][8'h11] = 32'hB0B0_0002;
      @(negedge clk);
      #2 rst[2] = 1'b1;
      #1 wr_en[2] = 1'b0;
      model_dout[2] = 32'h0;
      #2 rst[2] = 1'b0;
      // normal read so data_out is non-zero before the next reset
      @(negedge clk);
      model_req(2, 1'b1, 1'b0, 10'h040, 32'h0, ee, ed);
      send(2, 1'b1, 1'b0, 10'h040, 32'h0, r, e, dq);
      checks++;
      if (dq !== ed) begin errors++; $display("FAIL pre_reset_read: got %h expected %h", dq, ed); end
      // read in flight, reset during WAIT
      @(negedge clk);
      rd_en[2] = 1'b1; addr[2] = 10'h044;
      @(posedge clk);
      repeat (2) @(negedge clk);
      #2 rst[2] = 1'b1;
      #1;
      model_dout[2] = 32'h0;
      checks++;
      if (data_out[2] !== 32'h0) begin errors++; $display("FAIL async_reset_data: got %h expected 0", data_out[2]); end
      checks++;
      if (state[2] !== ST_IDLE || ready[2] !== 1'b0) begin
         errors++;
         $display("FAIL async_reset_state: got state %0d ready %b expected idle, 0", state[2], ready[2]);
      end
      rd_en[2] = 1'b0;
      #2 rst[2] = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (ready[2] === 1'b1) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin errors++; $display("FAIL discarded_read_ready: got ready expected none"); end
      checks++;
      if (data_out[2] !== model_dout[2]) begin errors++; $display("FAIL discarded_read_data: got %h expected %h", data_out[2], model_dout[2]); end
      // the write interrupted by reset is still in memory
      model_req(2, 1'b1, 1'b0, 10'h044, 32'h0, ee, ed);
      send(2, 1'b1, 1'b0, 10'h044, 32'h0, r, e, dq);
      checks++;
      if (dq !== ed) begin errors++; $display("FAIL committed_write: got %h expected %h", dq, ed); end
      // inputs changed during WAIT are ignored
      @(negedge clk);
      rd_en[2] = 1'b1; wr_en[2] = 1'b0; addr[2] = 10'h040; data_in[2] = 32'h0;
      model_req(2, 1'b1, 1'b0, 10'h040, 32'h0, ee, ed);
      @(posedge clk);
      @(negedge clk);
      addr[2] = 10'h044; wr_en[2] = 1'b1; data_in[2] = 32'hCCCC_CCCC;
      r = -1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (ready[2] === 1'b1) begin r = cyc; dq = data_out[2]; e = err[2]; break; end
      end
      rd_en[2] = 1'b0; wr_en[2] = 1'b0;
      checks++;
      if (r < 0 || dq !== ed || e !== ee) begin
         errors++;
         $display("FAIL latched_addr: got ready_cyc %0d data %h err %b expected data %h err %b", r, dq, e, ed, ee);
      end
      @(negedge clk);
      model_req(2, 1'b1, 1'b0, 10'h044, 32'h0, ee, ed);
      send(2, 1'b1, 1'b0, 10'h044, 32'h0, r, e, dq);
      checks++;
      if (dq !== ed) begin errors++; $display("FAIL ignored_wait_write: got %h expected %h", dq, ed); end
   endtask

   task automatic test_random(input int k);
      logic [7:0]  pool [6];
      int          c, r, prev_r, op, j;
      bit          gap;
      logic        e, ee, rd, wr;
      logic [31:0] dq, ed, d;
      logic [9:0]  a;
      for (int i = 0; i < 6; i++) begin
         pool[i] = 8'($urandom_range(0, 255));
         d = $urandom;
         a = {pool[i], 2'b00};
         @(negedge clk);
         model_req(k, 1'b0, 1'b1, a, d, ee, ed);
         send(k, 1'b0, 1'b1, a, d, r, e, dq);
         checks++;
         if (e !== ee) begin errors++; $display("FAIL rand_prefill_err dut%0d: got %b expected %b", k, e, ee); end
      end
      prev_r = 0;
      for (int i = 0; i < 30; i++) begin
         op = $urandom_range(0, 99);
         j  = $urandom_range(0, 5);
         d  = $urandom;
         a  = {pool[j], 2'b00};
         rd = 1'b0;
         wr = 1'b0;
         if (op < 40) wr = 1'b1;
         else if (op < 80) rd = 1'b1;
         else if (op < 90) begin
            a = {pool[j], 2'($urandom_range(1, 3))};
            if ($urandom_range(0, 1) == 1) rd = 1'b1; else wr = 1'b1;
         end else begin
            rd = 1'b1;
            wr = 1'b1;
         end
         gap = (i == 0) || ($urandom_range(0, 1) == 1);
         c = 0;
         if (gap) begin
            @(negedge clk);
            c = cyc;
         end
         model_req(k, rd, wr, a, d, ee, ed);
         send(k, rd, wr, a, d, r, e, dq);
         checks++;
         if (e !== ee) begin errors++; $display("FAIL rand_err dut%0d op%0d addr %h: got %b expected %b", k, i, a, e, ee); end
         checks++;
         if (dq !== ed) begin errors++; $display("FAIL rand_data dut%0d op%0d addr %h: got %h expected %h", k, i, a, dq, ed); end
         checks++;
         if (gap) begin
            if (r - c - 1 !== lat_of(k)) begin errors++; $display("FAIL rand_latency dut%0d: got %0d expected %0d", k, r - c - 1, lat_of(k)); end
         end else begin
            if (r - prev_r !== lat_of(k) + 2) begin errors++; $display("FAIL rand_throughput dut%0d: got %0d expected %0d", k, r - prev_r, lat_of(k) + 2); end
         end
         prev_r = r;
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_back_to_back();
      test_misaligned();
      test_conflict();
      test_reset_mid();
      test_random(0);
      test_random(1);
      test_random(2);
      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
